rot_position: RTL and testbench
===============================

ROT_POSITION -- requirements
Module: rot_position

Interface
REQ-001 Parameter WIDTH, default 8: position register width in bits (fixed 8 in this revision).
REQ-002 Parameter MAX_POS, default 99: upper position bound, 0 < MAX_POS <= 255.
REQ-003 Parameter WRAP, default 1: 1 = wrap-around at bounds, 0 = saturate.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 rotated  input  1  single-cycle detent pulse from the rotary decoder.
REQ-008 dir  input  1  direction, valid with rotated: 1 = cw/increment, 0 = ccw/decrement.
REQ-009 pos  output  8  current binary position.
REQ-010 bcd  output  12  {hundreds, tens, ones} BCD of a position snapshot, stable while upd_valid = 1.
REQ-011 upd_valid  output  1  new display value available for the LCD writer.
REQ-012 upd_ack  input  1  LCD writer has consumed bcd; sampled only while upd_valid = 1.

Function
REQ-013 On rotated = 1 at edge N, pos shall reflect the step at edge N; rotated = 0 leaves pos unchanged.
REQ-014 Increment at pos = MAX_POS shall give 0 when WRAP = 1, or hold MAX_POS when WRAP = 0.
REQ-015 Decrement at pos = 0 shall give MAX_POS when WRAP = 1, or hold 0 when WRAP = 0.
REQ-016 Internal flag dirty shall be set on every rotated pulse, including saturated steps that leave pos unchanged.
REQ-017 FSM states: IDLE, CONV, PRESENT.
REQ-018 IDLE: if dirty = 1, snapshot pos into the converter, clear dirty, and go to CONV; otherwise stay in IDLE.
REQ-019 If rotated coincides with the IDLE snapshot edge, dirty shall remain 1 (set wins), and the snapshot shall take the pre-step pos.
REQ-020 CONV: perform sequential double-dabble, one shift-and-add-3 iteration per cycle, 8 iterations, then go to PRESENT with the bcd register loaded.
REQ-021 PRESENT: upd_valid = 1 and bcd held constant; on upd_ack = 1 return to IDLE, with upd_valid low from the next cycle.
REQ-022 Snapshot to upd_valid latency shall be exactly 9 cycles (8 CONV cycles plus the transition into PRESENT).
REQ-023 Rotations during CONV or PRESENT shall update pos and set dirty, but shall not disturb the conversion or the presented bcd; the newest pos is converted after ack.
REQ-024 Any number of pulses while busy shall collapse into one subsequent update reflecting the final pos.
REQ-025 upd_ack outside PRESENT shall be ignored.
REQ-026 bcd digits shall never exceed 9; hundreds digit range 0..2.

Reset
REQ-027 Reset shall drive pos = 0, bcd = 12'h000, upd_valid = 0, dirty = 1, FSM = IDLE.
REQ-028 Reset mid-CONV or mid-PRESENT shall abort immediately, with no upd_valid glitch.
REQ-029 After reset release, one update for "000" shall be presented so the LCD is initialised.

Structure
REQ-030 Shared package rot_pkg shall hold the FSM state encoding, the CONV iteration count (8), and the BCD digit width (4).
REQ-031 Sub-module bin2bcd8 (start, bin[7:0], done, bcd[11:0]) shall implement the sequential double-dabble; rot_position shall own the counter, dirty flag and handshake.

Verification
REQ-032 Reset, then hold upd_ack = 0 -> upd_valid rises 10 cycles after release with bcd = 000; ack -> upd_valid low next cycle.
REQ-033 WRAP = 1, MAX_POS = 99: 100 cw pulses from 0 -> pos = 0; one ccw pulse -> pos = 99, bcd = 099 after ack cycle.
REQ-034 WRAP = 0: 120 cw pulses -> pos = 99 held; ccw at 0 -> pos stays 0, yet an update is still presented.
REQ-035 5 cw pulses during CONV with upd_ack withheld 20 cycles -> first bcd unchanged, exactly one further update showing the final pos.
REQ-036 rotated on the IDLE snapshot edge -> two updates presented, old value then new.
REQ-037 Assert rst while upd_valid = 1 -> upd_valid = 0 and pos = 0 asynchronously; the REQ-032 sequence recurs.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotary position display path: FSM encoding,
// double-dabble iteration count, BCD digit width and the add-3 digit helper.
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int CONV_ITERS = 8;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = 3 * DIGIT_W;

  // Double-dabble correction: a digit of 5 or more gets +3 before the shift
  // so that it carries correctly into the next decade.
  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
  endfunction

endpackage

// File: rtl/rot_position_if.sv
// Detent input, position output and the LCD update handshake, bundled.
// master: the rotary decoder / LCD writer side; slave: rot_position.
interface rot_position_if;
  import rot_pkg::*;

  logic             rotated;
  logic             dir;
  logic [7:0]       pos;
  logic [BCD_W-1:0] bcd;
  logic             upd_valid;
  logic             upd_ack;

  modport master (
    output rotated, dir, upd_ack,
    input  pos, bcd, upd_valid
  );

  modport slave (
    input  rotated, dir, upd_ack,
    output pos, bcd, upd_valid
  );

endinterface

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// start loads bin; one add-3-and-shift per cycle; done rises after the last
// iteration and stays high until the next start. bcd is only meaningful
// while done = 1.
module bin2bcd8
  import rot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(CONV_ITERS);

  // {bcd digits, remaining binary bits}
  logic [BCD_W+7:0] sr_q;
  logic [BCD_W+7:0] sr_next;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [BCD_W-1:0] adj;

  // Correct every digit, then shift the whole register left by one.
  // NOTE: every always_comb output gets a value before any branch or loop,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 3; i++) begin
      adj[i*DIGIT_W +: DIGIT_W] = add3(sr_q[8 + i*DIGIT_W +: DIGIT_W]);
    end
    sr_next = {adj[BCD_W-2:0], sr_q[7:0], 1'b0};
  end

  // Iteration sequencer and shift register.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      sr_q   <= {{BCD_W{1'b0}}, bin};
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      sr_q  <= sr_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(CONV_ITERS - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign bcd  = sr_q[BCD_W+7:8];

endmodule

// File: rtl/rot_position.sv
// Rotary encoder position counter with a BCD display update path.
// Each detent moves pos (wrap or saturate at 0 / MAX_POS) and marks the
// display dirty. When idle and dirty, pos is snapshotted into bin2bcd8; the
// result is presented on bcd with upd_valid until the LCD writer acks.
// Pulses arriving while busy collapse into one follow-up update.
module rot_position
  import rot_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_POS = 99,
  parameter int WRAP    = 1
) (
  input  logic          clk,
  input  logic          rst,
  rot_position_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_POS);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pos_q;
  logic             dirty_q;
  logic             snap;
  logic             load_bcd;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  // Position counter: one step per detent, wrapping or saturating at bounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else if (bus.rotated) begin
      if (bus.dir) begin
        if (pos_q == MAX_V) pos_q <= (WRAP != 0) ? '0 : MAX_V;
        else                pos_q <= pos_q + WIDTH'(1);
      end else begin
        if (pos_q == '0)    pos_q <= (WRAP != 0) ? MAX_V : '0;
        else                pos_q <= pos_q - WIDTH'(1);
      end
    end
  end

  // Dirty flag: set by any detent (even a saturated one) and wins over the
  // clear from a coincident snapshot. Starts set so the LCD gets "000".
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              dirty_q <= 1'b1;
    else if (bus.rotated) dirty_q <= 1'b1;
    else if (snap)        dirty_q <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d  = state_q;
    snap     = 1'b0;
    load_bcd = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          snap    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          load_bcd = 1'b1;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.upd_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Presented BCD value: captured once per conversion, held through PRESENT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bcd_q <= '0;
    else if (load_bcd) bcd_q <= conv_bcd;
  end

  bin2bcd8 u_bin2bcd8 (
    .clk   (clk),
    .rst   (rst),
    .start (snap),
    .bin   (pos_q),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign bus.pos       = pos_q;
  assign bus.bcd       = bcd_q;
  assign bus.upd_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_rot_position.sv
// Directed bench for rot_position: a wrapping instance (dut_w) and a
// saturating instance (dut_s), both MAX_POS = 99, sharing clk and rst.
module tb_rot_position;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rot_position_if if_w ();
  rot_position_if if_s ();

  rot_position #(.WIDTH(8), .MAX_POS(99), .WRAP(1)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (if_w)
  );

  rot_position #(.WIDTH(8), .MAX_POS(99), .WRAP(0)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  // Hold rotated high for n consecutive rising edges, then drop it.
  task automatic rotate_w(input logic d, input int n);
    @(negedge clk);
    if_w.rotated = 1'b1;
    if_w.dir     = d;
    repeat (n) @(negedge clk);
    if_w.rotated = 1'b0;
  endtask

  task automatic rotate_s(input logic d, input int n);
    @(negedge clk);
    if_s.rotated = 1'b1;
    if_s.dir     = d;
    repeat (n) @(negedge clk);
    if_s.rotated = 1'b0;
  endtask

  // One-cycle ack; returns on the negedge after the acking rising edge.
  task automatic ack_w();
    @(negedge clk);
    if_w.upd_ack = 1'b1;
    @(negedge clk);
    if_w.upd_ack = 1'b0;
  endtask

  task automatic ack_s();
    @(negedge clk);
    if_s.upd_ack = 1'b1;
    @(negedge clk);
    if_s.upd_ack = 1'b0;
  endtask

  task automatic ack_both();
    @(negedge clk);
    if_w.upd_ack = 1'b1;
    if_s.upd_ack = 1'b1;
    @(negedge clk);
    if_w.upd_ack = 1'b0;
    if_s.upd_ack = 1'b0;
  endtask

  // Count rising edges until upd_valid, bounded by limit.
  task automatic wait_w(input int limit, output int cycles);
    cycles = 0;
    while (if_w.upd_valid !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_s(input int limit, output int cycles);
    cycles = 0;
    while (if_s.upd_valid !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    logic seen;
    #3;
    n_cmp++;
    if (if_w.pos !== 8'd0 || if_s.pos !== 8'd0) begin
      n_bad++; $display("FAIL reset_pos: got %0d/%0d want 0/0", if_w.pos, if_s.pos);
    end
    n_cmp++;
    if (if_w.bcd !== 12'h000 || if_s.bcd !== 12'h000) begin
      n_bad++; $display("FAIL reset_bcd: got %h/%h want 000/000", if_w.bcd, if_s.bcd);
    end
    n_cmp++;
    if (if_w.upd_valid !== 1'b0 || if_s.upd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b/%b want 0/0", if_w.upd_valid, if_s.upd_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_w(30, c);
    n_cmp++;
    if (c !== 10 || if_s.upd_valid !== 1'b1) begin
      n_bad++; $display("FAIL init_latency: got %0d cycles (s valid %b) want 10 (1)", c, if_s.upd_valid);
    end
    n_cmp++;
    if (if_w.bcd !== 12'h000 || if_s.bcd !== 12'h000) begin
      n_bad++; $display("FAIL init_bcd: got %h/%h want 000/000", if_w.bcd, if_s.bcd);
    end
    ack_both();
    n_cmp++;
    if (if_w.upd_valid !== 1'b0 || if_s.upd_valid !== 1'b0) begin
      n_bad++; $display("FAIL init_ack_drop: got %b/%b want 0/0", if_w.upd_valid, if_s.upd_valid);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (if_w.upd_valid !== 1'b0 || if_s.upd_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL init_no_extra: got spurious upd_valid want none");
    end
  endtask

  task automatic test_wrap();
    int c;
    rotate_w(1'b1, 100);
    n_cmp++;
    if (if_w.pos !== 8'd0) begin
      n_bad++; $display("FAIL wrap_up_pos: got %0d want 0", if_w.pos);
    end
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h001) begin
      n_bad++; $display("FAIL wrap_first_bcd: got valid %b bcd %h want 1 001", if_w.upd_valid, if_w.bcd);
    end
    rotate_w(1'b0, 1);
    n_cmp++;
    if (if_w.pos !== 8'd99) begin
      n_bad++; $display("FAIL wrap_down_pos: got %0d want 99", if_w.pos);
    end
    ack_w();
    wait_w(30, c);
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h099) begin
      n_bad++; $display("FAIL wrap_bcd_099: got valid %b bcd %h want 1 099", if_w.upd_valid, if_w.bcd);
    end
    ack_w();
  endtask

  task automatic test_saturate();
    int c;
    rotate_s(1'b1, 120);
    n_cmp++;
    if (if_s.pos !== 8'd99) begin
      n_bad++; $display("FAIL sat_up_pos: got %0d want 99", if_s.pos);
    end
    n_cmp++;
    if (if_s.upd_valid !== 1'b1 || if_s.bcd !== 12'h001) begin
      n_bad++; $display("FAIL sat_first_bcd: got valid %b bcd %h want 1 001", if_s.upd_valid, if_s.bcd);
    end
    ack_s();
    wait_s(30, c);
    n_cmp++;
    if (if_s.upd_valid !== 1'b1 || if_s.bcd !== 12'h099) begin
      n_bad++; $display("FAIL sat_bcd_099: got valid %b bcd %h want 1 099", if_s.upd_valid, if_s.bcd);
    end
    ack_s();
    rotate_s(1'b0, 99);
    n_cmp++;
    if (if_s.pos !== 8'd0) begin
      n_bad++; $display("FAIL sat_down_pos: got %0d want 0", if_s.pos);
    end
    ack_s();
    wait_s(30, c);
    n_cmp++;
    if (if_s.upd_valid !== 1'b1 || if_s.bcd !== 12'h000) begin
      n_bad++; $display("FAIL sat_bcd_000: got valid %b bcd %h want 1 000", if_s.upd_valid, if_s.bcd);
    end
    ack_s();
    rotate_s(1'b0, 1);
    n_cmp++;
    if (if_s.pos !== 8'd0) begin
      n_bad++; $display("FAIL sat_hold0_pos: got %0d want 0", if_s.pos);
    end
    wait_s(30, c);
    n_cmp++;
    if (c !== 10 || if_s.upd_valid !== 1'b1 || if_s.bcd !== 12'h000) begin
      n_bad++; $display("FAIL sat_hold0_update: got %0d cycles valid %b bcd %h want 10 1 000", c, if_s.upd_valid, if_s.bcd);
    end
    ack_s();
  endtask

  task automatic test_busy();
    int c;
    logic held;
    logic seen;
    rotate_w(1'b1, 1);            // 99 -> 0, snapshot of 0 on the next edge
    for (int i = 0; i < 5; i++) rotate_w(1'b1, 1);
    n_cmp++;
    if (if_w.pos !== 8'd5) begin
      n_bad++; $display("FAIL busy_pos: got %0d want 5", if_w.pos);
    end
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h000) begin
      n_bad++; $display("FAIL busy_first_bcd: got valid %b bcd %h want 1 000", if_w.upd_valid, if_w.bcd);
    end
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h000) held = 1'b0;
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++; $display("FAIL busy_hold: got bcd %h valid %b want 000 held 20 cycles", if_w.bcd, if_w.upd_valid);
    end
    ack_w();
    n_cmp++;
    if (if_w.upd_valid !== 1'b0) begin
      n_bad++; $display("FAIL busy_ack_drop: got %b want 0", if_w.upd_valid);
    end
    wait_w(30, c);
    n_cmp++;
    if (c !== 10 || if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h005) begin
      n_bad++; $display("FAIL busy_second: got %0d cycles valid %b bcd %h want 10 1 005", c, if_w.upd_valid, if_w.bcd);
    end
    ack_w();
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (if_w.upd_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL busy_single_followup: got extra update want none");
    end
  endtask

  task automatic test_snapshot_edge();
    int c;
    rotate_w(1'b1, 2);            // second step lands on the snapshot edge
    wait_w(30, c);
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h006) begin
      n_bad++; $display("FAIL snap_old: got valid %b bcd %h want 1 006", if_w.upd_valid, if_w.bcd);
    end
    ack_w();
    wait_w(30, c);
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h007 || if_w.pos !== 8'd7) begin
      n_bad++; $display("FAIL snap_new: got valid %b bcd %h pos %0d want 1 007 7", if_w.upd_valid, if_w.bcd, if_w.pos);
    end
    ack_w();
  endtask

  task automatic test_ack_ignored();
    int c;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if_w.upd_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (if_w.upd_valid !== 1'b0) seen = 1'b1;
    end
    if_w.upd_ack = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL ack_idle: got upd_valid while idle want none");
    end
    rotate_w(1'b1, 1);            // 7 -> 8
    if_w.upd_ack = 1'b1;          // held through the snapshot edge and CONV
    repeat (4) @(negedge clk);
    if_w.upd_ack = 1'b0;
    wait_w(30, c);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h008) begin
      n_bad++; $display("FAIL ack_in_conv: got valid %b bcd %h want 1 008", if_w.upd_valid, if_w.bcd);
    end
    ack_w();
  endtask

  task automatic test_reset_mid();
    int c;
    rotate_w(1'b1, 1);            // 8 -> 9
    wait_w(30, c);
    n_cmp++;
    if (if_w.upd_valid !== 1'b1 || if_w.bcd !== 12'h009) begin
      n_bad++; $display("FAIL rmid_pre: got valid %b bcd %h want 1 009", if_w.upd_valid, if_w.bcd);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (if_w.upd_valid !== 1'b0 || if_w.pos !== 8'd0 || if_w.bcd !== 12'h000) begin
      n_bad++; $display("FAIL rmid_async: got valid %b pos %0d bcd %h want 0 0 000", if_w.upd_valid, if_w.pos, if_w.bcd);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_w(30, c);
    n_cmp++;
    if (c !== 10 || if_w.bcd !== 12'h000) begin
      n_bad++; $display("FAIL rmid_reinit: got %0d cycles bcd %h want 10 000", c, if_w.bcd);
    end
    ack_both();
    n_cmp++;
    if (if_w.upd_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_ack_drop: got %b want 0", if_w.upd_valid);
    end
  endtask

  initial begin
    if_w.rotated = 1'b0; if_w.dir = 1'b0; if_w.upd_ack = 1'b0;
    if_s.rotated = 1'b0; if_s.dir = 1'b0; if_s.upd_ack = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_busy();
    test_snapshot_edge();
    test_ack_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
